booth_seq_mul: RTL and testbench

Parametrised, sequential radix-4 Booth multiplier that computes the full 2·WIDTH-bit product of two WIDTH-bit operands. Each operand pair is selected as signed (two's complement) or unsigned. It replaces the fixed 32-bit combinational array multiplier wherever area matters more than latency. Operands enter through a valid/ready handshake and retire two multiplier bits per cycle. The result leaves through a second valid/ready handshake.

---
 rtl/mul_pkg.sv | 26 ++
 rtl/booth_enc.sv | 18 +
 rtl/booth_seq_mul.sv | 141 ++++++++++++++
 tb/tb_booth_seq_mul.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
// Imported by the encoder and the top level.
package mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef struct packed {
      logic neg;
      logic one;
      logic two;
   } booth_ctl_t;

   // Digits needed to cover the (WIDTH+2)-bit extended multiplier.
   function automatic int booth_digits(input int w);
      return w / 2 + 1;
   endfunction

   function automatic bit width_ok(input int w);
      return (w >= 4) && (w % 2 == 0);
   endfunction

endpackage

// File: rtl/booth_enc.sv
// Radix-4 Booth encoder: {x[i+1], x[i], x[i-1]} -> {neg, one, two}.
// Purely combinational; the zero digit is one = two = 0.
module booth_enc
   import mul_pkg::*;
(
   input  logic [2:0]  bits_i,
   output booth_ctl_t  ctl_o
);

   // Decode the three overlapping multiplier bits into a signed digit.
   always_comb begin
      ctl_o.neg = bits_i[2] & ~(bits_i[1] & bits_i[0]);
      ctl_o.one = bits_i[1] ^ bits_i[0];
      ctl_o.two = (bits_i[2] & ~bits_i[1] & ~bits_i[0])
                | (~bits_i[2] & bits_i[1] & bits_i[0]);
   end

endmodule

// File: rtl/booth_seq_mul.sv
// Sequential radix-4 Booth multiplier, two multiplier bits per cycle.
// Signed or unsigned operands, valid/ready handshakes on both sides.
module booth_seq_mul
   import mul_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   x,
   input  logic               is_signed,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] p,
   output logic               busy
);

   localparam int N  = booth_digits(WIDTH);
   localparam int CW = $clog2(N + 1);
   localparam int EW = WIDTH + 2;
   localparam int SW = WIDTH + 3;
   localparam int AW = 2 * WIDTH + 4;

   if (!width_ok(WIDTH)) begin : g_bad_width
      $error("booth_seq_mul: WIDTH must be even and >= 4");
   end

   state_e             st_q, st_d;
   logic [EW-1:0]      a_q, a_d;
   logic [EW-1:0]      m_q, m_d;
   logic               xm1_q, xm1_d;
   logic [AW-1:0]      acc_q, acc_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] p_q, p_d;

   booth_ctl_t         ctl;
   logic [SW-1:0]      a_sx;
   logic [SW-1:0]      pp;
   logic [SW-1:0]      hi_sx;
   logic [SW-1:0]      sum;
   logic [AW:0]        cat;
   logic [AW-1:0]      acc_nx;
   logic [EW-1:0]      m_nx;

   booth_enc u_enc (
      .bits_i ({m_q[1:0], xm1_q}),
      .ctl_o  (ctl)
   );

   assign a_sx  = {a_q[EW-1], a_q};
   assign hi_sx = {acc_q[AW-1], acc_q[AW-1:WIDTH+2]};
   assign sum   = hi_sx + pp;
   // Sum rejoins the low accumulator bits, then an arithmetic shift by 2.
   assign cat    = {sum, acc_q[WIDTH+1:0]};
   assign acc_nx = {cat[AW], cat[AW:2]};
   assign m_nx   = {{2{m_q[EW-1]}}, m_q[EW-1:2]};

   // Partial product d*a_ext, sign-extended to the adder width.
   always_comb begin
      pp = '0;
      unique case (1'b1)
         ctl.two: pp = a_sx << 1;
         ctl.one: pp = a_sx;
         default: pp = '0;
      endcase
      if (ctl.neg) begin
         pp = ~pp + SW'(1);
      end
   end

   // FSM and datapath next-state: load, iterate digits, hold result.
   always_comb begin
      st_d  = st_q;
      a_d   = a_q;
      m_d   = m_q;
      xm1_d = xm1_q;
      acc_d = acc_q;
      cnt_d = cnt_q;
      p_d   = p_q;
      unique case (1'b1)
         st_q == IDLE: begin
            if (in_valid) begin
               a_d   = is_signed ? {{2{a[WIDTH-1]}}, a}
                                 : {2'b00, a};
               m_d   = is_signed ? {{2{x[WIDTH-1]}}, x}
                                 : {2'b00, x};
               xm1_d = 1'b0;
               acc_d = '0;
               cnt_d = CW'(N);
               st_d  = CALC;
            end
         end
         st_q == CALC: begin
            acc_d = acc_nx;
            m_d   = m_nx;
            xm1_d = m_q[1];
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               st_d = DONE;
               p_d  = acc_nx[2*WIDTH-1:0];
            end
         end
         st_q == DONE: begin
            if (out_ready) begin
               st_d = IDLE;
            end
         end
         default: st_d = IDLE;
      endcase
   end

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q  <= IDLE;
         a_q   <= '0;
         m_q   <= '0;
         xm1_q <= 1'b0;
         acc_q <= '0;
         cnt_q <= '0;
         p_q   <= '0;
      end else begin
         st_q  <= st_d;
         a_q   <= a_d;
         m_q   <= m_d;
         xm1_q <= xm1_d;
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         p_q   <= p_d;
      end
   end

   assign in_ready  = (st_q == IDLE);
   assign busy      = (st_q != IDLE);
   assign out_valid = (st_q == DONE);
   assign p         = p_q;

endmodule

// File: tb/tb_booth_seq_mul.sv
// Directed bench for booth_seq_mul at WIDTH=32 and WIDTH=8.
// Latency, backpressure, mid-op reset and a small model-checked sweep.
module tb_booth_seq_mul;

   logic        clk;
   logic        rst_n;

   logic        iv32, ir32, s32, ov32, or32, bz32;
   logic [31:0] a32, x32;
   logic [63:0] p32;

   logic        iv8, ir8, s8, ov8, or8, bz8;
   logic [7:0]  a8, x8;
   logic [15:0] p8;

   int total;
   int bad;

   booth_seq_mul #(.WIDTH(32)) u_dut32 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv32),
      .in_ready  (ir32),
      .a         (a32),
      .x         (x32),
      .is_signed (s32),
      .out_valid (ov32),
      .out_ready (or32),
      .p         (p32),
      .busy      (bz32)
   );

   booth_seq_mul #(.WIDTH(8)) u_dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv8),
      .in_ready  (ir8),
      .a         (a8),
      .x         (x8),
      .is_signed (s8),
      .out_valid (ov8),
      .out_ready (or8),
      .p         (p8),
      .busy      (bz8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic op32(input logic [31:0] aa,
                       input logic [31:0] xx,
                       input logic        sg,
                       input logic [63:0] ex,
                       input string       tag,
                       input int          hold);
      int n;
      @(negedge clk);
      a32 = aa; x32 = xx; s32 = sg; iv32 = 1'b1;
      n = 0;
      while (!ir32 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk({tag, "_rdy"}, 64'(ir32), 64'd1);
      @(posedge clk); #1;
      iv32 = 1'b0;
      n = 0;
      while (!ov32 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_lat"}, 64'(n), 64'd17);
      chk({tag, "_p"}, p32, ex);
      repeat (hold) @(posedge clk);
      @(negedge clk);
      or32 = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_ret"}, 64'(ov32), 64'd0);
      or32 = 1'b0;
   endtask

   task automatic op8(input logic [7:0]  aa,
                      input logic [7:0]  xx,
                      input logic        sg,
                      input logic [15:0] ex,
                      input string       tag,
                      input int          hold);
      int n;
      @(negedge clk);
      a8 = aa; x8 = xx; s8 = sg; iv8 = 1'b1;
      n = 0;
      while (!ir8 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk({tag, "_rdy"}, 64'(ir8), 64'd1);
      @(posedge clk); #1;
      iv8 = 1'b0;
      n = 0;
      while (!ov8 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_lat"}, 64'(n), 64'd5);
      chk({tag, "_p"}, 64'(p8), 64'(ex));
      repeat (hold) @(posedge clk);
      @(negedge clk);
      or8 = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_ret"}, 64'(ov8), 64'd0);
      chk({tag, "_ir"}, 64'(ir8), 64'd1);
      or8 = 1'b0;
   endtask

   initial begin
      logic [31:0] ra, rx;
      logic [63:0] re;
      logic [7:0]  qa, qx;
      logic [15:0] qe;
      int          n;
      total = 0; bad = 0;
      rst_n = 1'b0;
      iv32 = 1'b0; s32 = 1'b0; or32 = 1'b0;
      a32 = '0; x32 = '0;
      iv8 = 1'b0; s8 = 1'b0; or8 = 1'b0;
      a8 = '0; x8 = '0;
      #12;
      chk("rst_ir", 64'(ir32), 64'd1);
      chk("rst_bz", 64'(bz32), 64'd0);
      chk("rst_ov", 64'(ov32), 64'd0);
      chk("rst_p", p32, 64'd0);
      chk("rst_p8", 64'(p8), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      op32(32'hFFFFFFFF, 32'h7, 1'b1,
           64'hFFFFFFFF_FFFFFFF9, "s_m1x7", 0);
      op32(32'h80000000, 32'h80000000, 1'b1,
           64'h40000000_00000000, "s_min2", 1);
      op32(32'h80000000, 32'h80000000, 1'b0,
           64'h40000000_00000000, "u_min2", 0);
      op32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0,
           64'hFFFFFFFE_00000001, "u_max2", 2);
      op32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1,
           64'h1, "s_m1m1", 0);
      op32(32'h7FFFFFFF, 32'h80000000, 1'b1,
           64'hC0000000_80000000, "s_maxmin", 0);
      op32(32'h12345678, 32'h0, 1'b0, 64'h0, "u_zero", 0);

      op8(8'hFF, 8'h02, 1'b0, 16'h01FE, "u8_ffx2", 0);
      op8(8'hFF, 8'h02, 1'b1, 16'hFFFE, "s8_ffx2", 0);
      op8(8'h80, 8'h80, 1'b1, 16'h4000, "s8_min2", 0);
      op8(8'h80, 8'h80, 1'b0, 16'h4000, "u8_min2", 0);
      op8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u8_max2", 1);
      op8(8'h7F, 8'h81, 1'b1, 16'hC0FF, "s8_mix", 0);

      // Backpressure with a second pair offered throughout.
      @(negedge clk);
      a32 = 32'd3; x32 = 32'd5; s32 = 1'b0; iv32 = 1'b1;
      @(posedge clk); #1;
      a32 = 32'd7; x32 = 32'd9;
      n = 0;
      while (!ov32 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("bp_lat", 64'(n), 64'd17);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("bp_p", p32, 64'd15);
         chk("bp_ov", 64'(ov32), 64'd1);
         chk("bp_ir", 64'(ir32), 64'd0);
      end
      or32 = 1'b1;
      @(posedge clk); #1;
      or32 = 1'b0;
      chk("bp_ret_ov", 64'(ov32), 64'd0);
      chk("bp_ret_ir", 64'(ir32), 64'd1);
      chk("bp_no_acc", 64'(bz32), 64'd0);
      @(posedge clk); #1;
      iv32 = 1'b0;
      chk("bp_acc2", 64'(bz32), 64'd1);
      n = 0;
      while (!ov32 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("bp2_lat", 64'(n), 64'd17);
      chk("bp2_p", p32, 64'd63);
      or32 = 1'b1;
      @(posedge clk); #1;
      or32 = 1'b0;

      // Reset during CALC aborts cleanly.
      @(negedge clk);
      a32 = 32'd100; x32 = 32'd200; s32 = 1'b0; iv32 = 1'b1;
      @(posedge clk); #1;
      iv32 = 1'b0;
      repeat (8) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("mr_ov", 64'(ov32), 64'd0);
      chk("mr_p", p32, 64'd0);
      chk("mr_ir", 64'(ir32), 64'd1);
      chk("mr_bz", 64'(bz32), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      op32(32'd100, 32'd200, 1'b0, 64'h4E20, "post_rst", 0);

      // Model-checked sweep with random retirement delay.
      for (int i = 0; i < 60; i++) begin
         ra = $urandom;
         rx = $urandom;
         re = {32'h0, ra} * {32'h0, rx};
         op32(ra, rx, 1'b0, re, "r32u", $urandom_range(0, 3));
         re = {{32{ra[31]}}, ra} * {{32{rx[31]}}, rx};
         op32(ra, rx, 1'b1, re, "r32s", $urandom_range(0, 3));
      end
      for (int i = 0; i < 60; i++) begin
         qa = 8'($urandom);
         qx = 8'($urandom);
         qe = {8'h0, qa} * {8'h0, qx};
         op8(qa, qx, 1'b0, qe, "r8u", $urandom_range(0, 3));
         qe = {{8{qa[7]}}, qa} * {{8{qx[7]}}, qx};
         op8(qa, qx, 1'b1, qe, "r8s", $urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
